// File: rtl/rename_map_table.sv
// Checkpointed register alias table. Each architectural register maps to the
// ROB tag of its youngest in-flight producer; tag 0 means the value is in the
// architectural register file. Supports multi-slot rename with intra-group
// bypass, tag-matched commit clears, and branch snapshots with 1-cycle restore.
module rename_map_table #(
    parameter int unsigned ROBsize  = 32,
    parameter int unsigned TAGW     = $clog2(ROBsize + 1),
    parameter int unsigned NUM_ARCH = 32,
    parameter int unsigned AW       = $clog2(NUM_ARCH),
    parameter int unsigned ZERO_REG = 31,
    parameter int unsigned WIDTH    = 2,
    parameter int unsigned NUM_CKPT = 4,
    parameter int unsigned CKW      = $clog2(NUM_CKPT)
) (
    input  logic                                      clk,
    input  logic                                      reset,
    input  logic [WIDTH*AW-1:0]                       decodeReadAddr1_i,
    input  logic [WIDTH*AW-1:0]                       decodeReadAddr2_i,
    output logic [WIDTH*TAGW-1:0]                     decodeReadData1_o,
    output logic [WIDTH*TAGW-1:0]                     decodeReadData2_o,
    input  logic [WIDTH*AW-1:0]                       decodeWriteAddr_i,
    input  logic [WIDTH*TAGW-1:0]                     decodeWriteData_i,
    input  logic [WIDTH-1:0]                          decodeRegWrite_i,
    input  logic [WIDTH*AW-1:0]                       commitAddr_i,
    input  logic [WIDTH*TAGW-1:0]                     commitTag_i,
    input  logic [WIDTH-1:0]                          commitValid_i,
    input  logic                                      ckptTake_i,
    input  logic [((WIDTH > 1) ? $clog2(WIDTH) : 1)-1:0] ckptSlot_i,
    output logic [CKW-1:0]                            ckptId_o,
    output logic                                      ckptFull_o,
    input  logic                                      ckptRelease_i,
    input  logic                                      restore_i,
    input  logic [CKW-1:0]                            restoreId_i,
    input  logic                                      flush_i
);

    localparam int unsigned CNTW = CKW + 1;
    localparam logic [AW-1:0] ZERO_ADDR = AW'(ZERO_REG);

    // Live map, snapshot bank and circular checkpoint pointers.
    logic [TAGW-1:0] map_q  [NUM_ARCH];
    logic [TAGW-1:0] map_d  [NUM_ARCH];
    logic [TAGW-1:0] ckpt_q [NUM_CKPT][NUM_ARCH];
    logic [TAGW-1:0] ckpt_d [NUM_CKPT][NUM_ARCH];
    logic [CKW-1:0]  head_q, head_d;
    logic [CKW-1:0]  tail_q, tail_d;
    logic [CNTW-1:0] count_q, count_d;

    logic            take_ok;
    logic            rel_ok;
    logic [CKW-1:0]  head_rel;

    // Source lookup for slot k: map entry, overridden by the youngest older slot writing it.
    function automatic logic [TAGW-1:0] lookup(input logic [AW-1:0] a, input int unsigned k);
        logic [TAGW-1:0] t;
        t = (a == ZERO_ADDR) ? '0 : map_q[a];
        for (int unsigned j = 0; j < k; j++) begin
            if (decodeRegWrite_i[j] && (decodeWriteAddr_i[j*AW +: AW] == a) && (a != ZERO_ADDR)) begin
                t = decodeWriteData_i[j*TAGW +: TAGW];
            end
        end
        return t;
    endfunction

    // Combinational source-tag reads with intra-group bypass.
    always_comb begin
        decodeReadData1_o = '0;
        decodeReadData2_o = '0;
        for (int unsigned k = 0; k < WIDTH; k++) begin
            decodeReadData1_o[k*TAGW +: TAGW] = lookup(decodeReadAddr1_i[k*AW +: AW], k);
            decodeReadData2_o[k*TAGW +: TAGW] = lookup(decodeReadAddr2_i[k*AW +: AW], k);
        end
    end

    // Status outputs come straight from registered pointer state.
    assign ckptId_o   = tail_q;
    assign ckptFull_o = (count_q == CNTW'(NUM_CKPT));

    // Checkpoint pointer handshakes; restore/flush suppress takes.
    always_comb begin
        take_ok  = ckptTake_i && !ckptFull_o && !restore_i && !flush_i;
        rel_ok   = ckptRelease_i && (count_q != '0) && !flush_i;
        head_rel = head_q + CKW'(rel_ok);
    end

    // Next map, snapshot bank and pointers.
    always_comb begin : next_state
        logic            hit_live;
        logic            hit_rst;
        logic            hit_ck;
        logic            wr_all;
        logic            wr_part;
        logic [TAGW-1:0] val_all;
        logic [TAGW-1:0] val_part;
        logic [TAGW-1:0] live_clr;
        logic [TAGW-1:0] snap_ent;

        map_d    = map_q;
        ckpt_d   = ckpt_q;
        head_d   = head_q;
        tail_d   = tail_q;
        count_d  = count_q;
        hit_live = 1'b0;
        hit_rst  = 1'b0;
        hit_ck   = 1'b0;
        wr_all   = 1'b0;
        wr_part  = 1'b0;
        val_all  = '0;
        val_part = '0;
        live_clr = '0;
        snap_ent = '0;

        for (int unsigned r = 0; r < NUM_ARCH; r++) begin
            // Commit tag matches against the live entry and the restore source.
            hit_live = 1'b0;
            hit_rst  = 1'b0;
            for (int unsigned c = 0; c < WIDTH; c++) begin
                if (commitValid_i[c] && (commitAddr_i[c*AW +: AW] == AW'(r))) begin
                    if (map_q[r] == commitTag_i[c*TAGW +: TAGW]) begin
                        hit_live = 1'b1;
                    end
                    if (ckpt_q[restoreId_i][r] == commitTag_i[c*TAGW +: TAGW]) begin
                        hit_rst = 1'b1;
                    end
                end
            end
            live_clr = hit_live ? '0 : map_q[r];

            // Youngest write to r over all slots, and over the slots the branch covers.
            wr_all   = 1'b0;
            wr_part  = 1'b0;
            val_all  = '0;
            val_part = '0;
            for (int unsigned j = 0; j < WIDTH; j++) begin
                if (decodeRegWrite_i[j] && (decodeWriteAddr_i[j*AW +: AW] == AW'(r))
                    && (decodeWriteAddr_i[j*AW +: AW] != ZERO_ADDR)) begin
                    wr_all  = 1'b1;
                    val_all = decodeWriteData_i[j*TAGW +: TAGW];
                    if (int'(j) <= int'(ckptSlot_i)) begin
                        wr_part  = 1'b1;
                        val_part = decodeWriteData_i[j*TAGW +: TAGW];
                    end
                end
            end
            snap_ent = wr_part ? val_part : live_clr;

            // Every stored snapshot sees the same tag-matched clear.
            for (int unsigned k = 0; k < NUM_CKPT; k++) begin
                hit_ck = 1'b0;
                for (int unsigned c = 0; c < WIDTH; c++) begin
                    if (commitValid_i[c] && (commitAddr_i[c*AW +: AW] == AW'(r))
                        && (ckpt_q[k][r] == commitTag_i[c*TAGW +: TAGW])) begin
                        hit_ck = 1'b1;
                    end
                end
                ckpt_d[k][r] = hit_ck ? '0 : ckpt_q[k][r];
            end

            if (restore_i) begin
                map_d[r] = hit_rst ? '0 : ckpt_q[restoreId_i][r];
            end else begin
                map_d[r] = wr_all ? val_all : live_clr;
                if (take_ok) begin
                    ckpt_d[tail_q][r] = snap_ent;
                end
            end
        end

        if (flush_i) begin
            for (int unsigned r = 0; r < NUM_ARCH; r++) begin
                map_d[r] = '0;
            end
            head_d  = '0;
            tail_d  = '0;
            count_d = '0;
        end else if (restore_i) begin
            head_d  = head_rel;
            tail_d  = restoreId_i;
            count_d = {1'b0, CKW'(restoreId_i - head_rel)};
        end else begin
            head_d  = head_rel;
            tail_d  = tail_q + CKW'(take_ok);
            count_d = count_q + CNTW'(take_ok) - CNTW'(rel_ok);
        end
    end

    // State registers with asynchronous active-low clear.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int unsigned r = 0; r < NUM_ARCH; r++) begin
                map_q[r] <= '0;
            end
            for (int unsigned k = 0; k < NUM_CKPT; k++) begin
                for (int unsigned r = 0; r < NUM_ARCH; r++) begin
                    ckpt_q[k][r] <= '0;
                end
            end
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            map_q   <= map_d;
            ckpt_q  <= ckpt_d;
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
    end

endmodule

// File: doc/rename_map_table.md
# rename_map_table

Multi-slot, checkpointed register alias table for the out-of-order core. Maps each architectural register to the ROB tag of its youngest in-flight producer; tag 0 means "value lives in the architectural register file". Sits between decode and the reservation stations/ROB. Supports `WIDTH` renames per cycle with intra-group bypass, `WIDTH` tag-matched commit clears, and `NUM_CKPT` branch snapshots with single-cycle restore.

## Interface
- `ROBsize`, default 32: ROB entries; valid tags are 1..ROBsize.
- `TAGW`, default $clog2(ROBsize+1): map entry / tag width.
- `NUM_ARCH`, default 32: architectural registers.
- `AW`, default $clog2(NUM_ARCH): register address width.
- `ZERO_REG`, default 31: hard-wired register; always reads 0; writes to it are dropped.
- `WIDTH`, default 2: decode/commit slots per cycle.
- `NUM_CKPT`, default 4: checkpoint slots, power of two.
- `CKW`, default $clog2(NUM_CKPT): checkpoint id width.

Ports:
- `clk`  in  1  clock; all state updates on rising edge.
- `reset`  in  1  asynchronous, active-low; clears all map entries and checkpoints to 0.
- `decodeReadAddr1_i`, `decodeReadAddr2_i`  in  WIDTH*AW  source registers, slot k at bits [k*AW +: AW].
- `decodeReadData1_o`, `decodeReadData2_o`  out  WIDTH*TAGW  source tags (combinational).
- `decodeWriteAddr_i`  in  WIDTH*AW  destination registers.
- `decodeWriteData_i`  in  WIDTH*TAGW  newly allocated ROB tags.
- `decodeRegWrite_i`  in  WIDTH  per-slot write enable.
- `commitAddr_i`  in  WIDTH*AW  committing destination register.
- `commitTag_i`  in  WIDTH*TAGW  committing ROB tag.
- `commitValid_i`  in  WIDTH  per-slot commit valid.
- `ckptTake_i`  in  1  take a snapshot this cycle.
- `ckptSlot_i`  in  $clog2(WIDTH)  branch slot; snapshot includes writes of slots 0..ckptSlot_i.
- `ckptId_o`  out  CKW  id assigned to a take this cycle (tail pointer).
- `ckptFull_o`  out  1  all checkpoints in use.
- `ckptRelease_i`  in  1  oldest branch resolved correctly; free the head checkpoint.
- `restore_i`  in  1  mispredict; restore the map from `restoreId_i`.
- `restoreId_i`  in  CKW  checkpoint to restore.
- `flush_i`  in  1  full flush (exception); map becomes all 0.

## Operation
- Read: slot k reads the map entry, overridden by the highest slot j<k with write enable, same address, and address ≠ ZERO_REG. Address ZERO_REG returns 0.
- Write: at the edge, each enabled slot writes its tag. If several slots write the same register, the highest slot wins. ZERO_REG writes are dropped.
- Commit clear: for each valid commit slot, if the entry at commitAddr equals commitTag, the entry is set to 0. The clear is suppressed if any decode write targets that register in the same cycle. The same tag-compare clear is applied to every valid checkpoint copy of that register.
- Checkpoint buffer: circular, with head, tail and count (0..NUM_CKPT).
  - Take, when not full: snapshot[tail] = map after slots 0..ckptSlot_i writes and after this cycle's commit clears; tail++ and count++.
  - Take while `ckptFull_o` is asserted is ignored; the frontend stalls.
- Release: head++ and count--. Ignored when count==0.
- Restore:
  - Map = snapshot[restoreId_i], with this cycle's commit clears applied.
  - tail = restoreId_i, freeing that checkpoint and all younger ones; count = (restoreId_i − head') mod NUM_CKPT, where head' includes a same-cycle release.
  - Decode writes and take are ignored in a restore cycle.
  - Restore with release and restoreId_i==head is illegal.
- Flush: map all 0; head = tail = count = 0; takes, writes, releases and restores are ignored. Commit clears are irrelevant.
- Priority: reset > flush > restore > (decode writes, take, release, commit clears).

## Timing
- Reads are combinational: address to data in the same cycle.
- Writes and clears are visible to reads on the next cycle. A commit clear is not bypassed to same-cycle reads.
- Restore and flush take effect in one cycle; the map is correct on the cycle after assertion.
- `ckptId_o` and `ckptFull_o` are functions of registered state, with no input dependence.
- Reset values: all entries and snapshots 0; `ckptId_o`=0; `ckptFull_o`=0; read outputs 0 for any address.
- Pointers wrap modulo NUM_CKPT. Full and empty are distinguished by count, not by pointer equality.

## Test plan
- Reset, then WIDTH=2 group: slot0 writes r3←5, slot1 reads r3 and writes r3←6 → slot1 reads 5 the same cycle; the next cycle reads r3=6. A write to r31←7 reads back as 0.
- r4=9: commit (r4, tag 9) → r4=0 next cycle. Commit (r4, 9) while r4=10 → r4 stays 10. Commit (r4, 9) with a same-cycle decode write r4←11 → r4=11.
- Take with ckptSlot=0 while slot0 writes r1←2 and slot1 writes r1←3 → ckptId_o=0. Later write r1←12, then restore id 0 → r1=2; count returns to 0.
- Take 4 checkpoints → ckptFull_o=1; a 5th take is ignored. Release → full deasserts; the next take gets id 0 (wrap-around).
- Checkpoint holds r2=8. Commit (r2, 8), then restore → r2=0 (snapshot was cleared).
- Mid-operation with 3 checkpoints live: flush → map all 0, count=0. Assert reset low asynchronously mid-cycle → outputs go to 0 immediately.
